// File: rtl/game_sprite_engine.sv
// Dodging-game pixel generator: game FSM, sprite motion with clamping, lives,
// post-hit invulnerability and goal detection, producing a registered 12-bit pixel.
module game_sprite_engine #(
   parameter int          H_ACTIVE      = 640,
   parameter int          V_ACTIVE      = 480,
   parameter int          SPRITE_SIZE   = 16,
   parameter int          STEP          = 2,
   parameter int          LIVES         = 3,
   parameter int          INVULN_FRAMES = 60,
   parameter int          START_X       = 0,
   parameter int          START_Y       = 464,
   parameter int          GOAL_X0       = 610,
   parameter int          GOAL_Y1       = 30,
   parameter logic [11:0] SPRITE_RGB    = 12'h00F,
   parameter logic [11:0] OBST_RGB      = 12'hFFF,
   parameter logic [11:0] GOAL_RGB      = 12'hF00,
   parameter logic [11:0] LIFE_RGB      = 12'hF0F,
   parameter logic [11:0] BG_RGB        = 12'h000,
   parameter logic [11:0] IDLE_RGB      = 12'h0F0,
   parameter logic [11:0] WON_RGB       = 12'hFFF,
   parameter logic [11:0] LOST_RGB      = 12'hF0F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        video_on,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        key_up,
   input  logic        key_down,
   input  logic        key_left,
   input  logic        key_right,
   input  logic        key_start,
   input  logic        obstacle_on,
   output logic [11:0] rgb,
   output logic [1:0]  game_state,
   output logic [2:0]  lives,
   output logic        frame_tick
);

   // state  | meaning
   // S_IDLE | attract screen, waiting for start
   // S_PLAY | game running, sprite moves on frame ticks
   // S_WON  | sprite reached goal, waiting for start
   // S_LOST | lives exhausted, waiting for start
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_WON, S_LOST} state_t;
   typedef enum logic [2:0] {D_NONE, D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

   localparam int X_MAX = H_ACTIVE - SPRITE_SIZE;
   localparam int Y_MAX = V_ACTIVE - SPRITE_SIZE;
   localparam int IW_RAW = $clog2(INVULN_FRAMES + 1);
   localparam int IW = (IW_RAW < 3) ? 3 : IW_RAW;

   state_t        state;
   dir_t          dir;
   logic [9:0]    sx, sy;
   logic [IW-1:0] invuln;
   logic          hit, key_start_q;

   logic          start_rise, sprite_on, blank, goal_hit, goal_px, pip_on;
   logic [10:0]   sum_x, sum_y;
   logic [9:0]    nx, ny;
   logic [11:0]   next_rgb;

   assign game_state = state;
   assign frame_tick = (x == 10'd0) && (y == 10'(V_ACTIVE + 1));
   assign start_rise = key_start & ~key_start_q;

   assign sprite_on = ({1'b0, x} >= {1'b0, sx}) && ({1'b0, x} <= {1'b0, sx} + 11'(SPRITE_SIZE - 1)) &&
                      ({1'b0, y} >= {1'b0, sy}) && ({1'b0, y} <= {1'b0, sy} + 11'(SPRITE_SIZE - 1));
   assign blank     = (invuln != '0) && invuln[2];
   assign goal_hit  = ({1'b0, sx} + 11'(SPRITE_SIZE - 1) >= 11'(GOAL_X0)) && (sy <= 10'(GOAL_Y1));
   assign goal_px   = (x >= 10'(GOAL_X0)) && (y <= 10'(GOAL_Y1));

   always_comb begin
      pip_on = 1'b0;
      for (int i = 0; i < LIVES; i++) begin
         if ((3'(i) < lives) && (y >= 10'd4) && (y <= 10'd11) &&
             (x >= 10'(4 + 12 * i)) && (x <= 10'(11 + 12 * i)))
            pip_on = 1'b1;
      end
   end

   // 11-bit sums so a right/down step near the edge clamps instead of wrapping
   always_comb begin
      sum_x = {1'b0, sx} + 11'(STEP);
      sum_y = {1'b0, sy} + 11'(STEP);
      nx    = sx;
      ny    = sy;
      case (dir)
         D_UP:    ny = (sy < 10'(STEP)) ? 10'd0 : sy - 10'(STEP);
         D_DOWN:  ny = (sum_y > 11'(Y_MAX)) ? 10'(Y_MAX) : sum_y[9:0];
         D_LEFT:  nx = (sx < 10'(STEP)) ? 10'd0 : sx - 10'(STEP);
         D_RIGHT: nx = (sum_x > 11'(X_MAX)) ? 10'(X_MAX) : sum_x[9:0];
         default: ;
      endcase
   end

   always_comb begin
      next_rgb = BG_RGB;
      if (!video_on)
         next_rgb = 12'h000;
      else begin
         case (state)
            S_IDLE: next_rgb = IDLE_RGB;
            S_WON:  next_rgb = WON_RGB;
            S_LOST: next_rgb = LOST_RGB;
            default: begin
               if (sprite_on && !blank) next_rgb = SPRITE_RGB;
               else if (obstacle_on)    next_rgb = OBST_RGB;
               else if (goal_px)        next_rgb = GOAL_RGB;
               else if (pip_on)         next_rgb = LIFE_RGB;
               else                     next_rgb = BG_RGB;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         lives       <= 3'(LIVES);
         sx          <= 10'(START_X);
         sy          <= 10'(START_Y);
         dir         <= D_NONE;
         invuln      <= '0;
         hit         <= 1'b0;
         key_start_q <= 1'b0;
         rgb         <= 12'h000;
      end else begin
         key_start_q <= key_start;
         rgb         <= next_rgb;
         case (state)
            S_IDLE: begin
               if (start_rise) begin
                  state  <= S_PLAY;
                  lives  <= 3'(LIVES);
                  sx     <= 10'(START_X);
                  sy     <= 10'(START_Y);
                  dir    <= D_NONE;
                  invuln <= '0;
                  hit    <= 1'b0;
               end
            end
            S_PLAY: begin
               if (key_up)         dir <= D_UP;
               else if (key_down)  dir <= D_DOWN;
               else if (key_left)  dir <= D_LEFT;
               else if (key_right) dir <= D_RIGHT;
               // movement uses the direction held before this edge
               if (frame_tick) begin
                  hit <= 1'b0;
                  if (hit) begin
                     lives  <= lives - 3'd1;
                     sx     <= 10'(START_X);
                     sy     <= 10'(START_Y);
                     dir    <= D_NONE;
                     invuln <= IW'(INVULN_FRAMES);
                     if (lives == 3'd1) state <= S_LOST;
                  end else if (goal_hit) begin
                     state <= S_WON;
                  end else begin
                     sx <= nx;
                     sy <= ny;
                     if (invuln != '0) invuln <= invuln - IW'(1);
                  end
               end else if (video_on && sprite_on && obstacle_on && (invuln == '0)) begin
                  hit <= 1'b1;
               end
            end
            default: begin
               if (start_rise) state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_sprite_engine.sv
// Randomised scoreboard bench for game_sprite_engine against a frame-level game model.
module tb_game_sprite_engine;
   logic        clk = 1'b0;
   logic        reset;
   logic        video_on = 1'b0, key_start = 1'b0, obstacle_on = 1'b0;
   logic [9:0]  x = '0, y = '0;
   logic        key_up, key_down, key_left, key_right;
   logic [11:0] rgb;
   logic [1:0]  game_state;
   logic [2:0]  lives;
   logic        frame_tick;
   logic [3:0]  held = 4'b0000;  // up, down, left, right

   assign key_up    = held[3];
   assign key_down  = held[2];
   assign key_left  = held[1];
   assign key_right = held[0];

   game_sprite_engine dut (
      .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
      .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
      .key_start(key_start), .obstacle_on(obstacle_on), .rgb(rgb),
      .game_state(game_state), .lives(lives), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] rgb;
      logic [1:0]  st;
      logic [2:0]  lv;
      logic        tk;
   } exp_t;
   exp_t sb[$];
   int vectors = 0, miscompares = 0;

   // game model: 0 IDLE, 1 PLAY, 2 WON, 3 LOST; dir 0 none, 1 up, 2 down, 3 left, 4 right
   int m_state, m_lives, m_sx, m_sy, m_dir, m_inv;
   bit m_hit, m_kq;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("rgb", int'(rgb), int'(e.rgb));
         chk("game_state", int'(game_state), int'(e.st));
         chk("lives", int'(lives), int'(e.lv));
         chk("frame_tick", int'(frame_tick), int'(e.tk));
      end
   end

   task automatic m_reset();
      m_state = 0; m_lives = 3; m_sx = 0; m_sy = 464; m_dir = 0; m_inv = 0; m_hit = 0; m_kq = 0;
   endtask

   function automatic bit in_spr(int px, int py);
      return px >= m_sx && px < m_sx + 16 && py >= m_sy && py < m_sy + 16;
   endfunction

   function automatic logic [11:0] m_pix(bit vo, int px, int py, bit ob);
      if (!vo) return 12'h000;
      if (m_state == 0) return 12'h0F0;
      if (m_state == 2) return 12'hFFF;
      if (m_state == 3) return 12'hF0F;
      if (in_spr(px, py) && !(m_inv > 0 && (m_inv / 4) % 2 == 1)) return 12'h00F;
      if (ob) return 12'hFFF;
      if (px >= 610 && py <= 30) return 12'hF00;
      if (py >= 4 && py <= 11 && px >= 4 && (px - 4) % 12 < 8 && (px - 4) / 12 < m_lives) return 12'hF0F;
      return 12'h000;
   endfunction

   // One clock: drive inputs, predict, advance the model, push the expectation at the edge.
   task automatic cyc(input bit vo, input int px, input int py, input bit ob, input bit st);
      exp_t e;
      bit sr, tick;
      int old;
      video_on = vo; x = 10'(px); y = 10'(py); obstacle_on = ob; key_start = st;
      e.rgb = m_pix(vo, px, py, ob);
      e.tk = (px == 0 && py == 481);
      sr = st && !m_kq;
      m_kq = st;
      tick = e.tk;
      old = m_dir;
      case (m_state)
         0: if (sr) begin
               m_state = 1; m_lives = 3; m_sx = 0; m_sy = 464; m_dir = 0; m_inv = 0; m_hit = 0;
            end
         1: begin
               if (held[3]) m_dir = 1;
               else if (held[2]) m_dir = 2;
               else if (held[1]) m_dir = 3;
               else if (held[0]) m_dir = 4;
               if (tick) begin
                  if (m_hit) begin
                     m_lives--; m_sx = 0; m_sy = 464; m_dir = 0; m_inv = 60;
                     if (m_lives == 0) m_state = 3;
                  end else if (m_sx + 15 >= 610 && m_sy <= 30) begin
                     m_state = 2;
                  end else begin
                     if (old == 1) m_sy = (m_sy - 2 < 0) ? 0 : m_sy - 2;
                     if (old == 2) m_sy = (m_sy + 2 > 464) ? 464 : m_sy + 2;
                     if (old == 3) m_sx = (m_sx - 2 < 0) ? 0 : m_sx - 2;
                     if (old == 4) m_sx = (m_sx + 2 > 624) ? 624 : m_sx + 2;
                     if (m_inv > 0) m_inv--;
                  end
                  m_hit = 0;
               end else if (vo && ob && in_spr(px, py) && m_inv == 0) begin
                  m_hit = 1;
               end
            end
         default: if (sr) m_state = 0;
      endcase
      e.st = 2'(m_state);
      e.lv = 3'(m_lives);
      @(posedge clk);
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic probe(input int n, input int ob_pct);
      for (int i = 0; i < n; i++) begin
         int px, py;
         case ($urandom_range(0, 3))
            0: begin px = m_sx + $urandom_range(0, 17) - 1; py = m_sy + $urandom_range(0, 17) - 1; end
            1: begin px = $urandom_range(0, 40); py = $urandom_range(0, 14); end
            2: begin px = $urandom_range(600, 639); py = $urandom_range(20, 40); end
            default: begin px = $urandom_range(0, 639); py = $urandom_range(0, 479); end
         endcase
         if (px < 0) px = 0;
         if (py < 0) py = 0;
         cyc($urandom_range(0, 7) != 0, px, py, $urandom_range(0, 99) < ob_pct, 1'b0);
      end
   endtask

   task automatic frame(input int n);
      probe(n, 0);
      cyc(1'b0, 0, 481, 1'b0, 1'b0);
   endtask

   task automatic press_start();
      cyc(1'b1, 100, 100, 1'b0, 1'b1);
      cyc(1'b1, 101, 100, 1'b0, 1'b1);
      cyc(1'b1, 102, 100, 1'b0, 1'b0);
   endtask

   task automatic hit_frame();
      cyc(1'b1, m_sx + 3, m_sy + 3, 1'b1, 1'b0);
      cyc(1'b0, 0, 481, 1'b0, 1'b0);
   endtask

   task automatic edge_probe();
      cyc(1'b1, m_sx, m_sy, 1'b0, 1'b0);
      cyc(1'b1, m_sx + 15, m_sy + 15, 1'b0, 1'b0);
      if (m_sx > 0) cyc(1'b1, m_sx - 1, m_sy, 1'b0, 1'b0);
      cyc(1'b1, m_sx + 16, m_sy + 15, 1'b0, 1'b0);
      cyc(1'b0, m_sx + 4, m_sy + 4, 1'b0, 1'b0);
   endtask

   task automatic pip_probe();
      cyc(1'b1, 6, 6, 1'b0, 1'b0);
      cyc(1'b1, 20, 6, 1'b0, 1'b0);
      cyc(1'b1, 30, 6, 1'b0, 1'b0);
      cyc(1'b1, 26, 6, 1'b0, 1'b0);
   endtask

   task automatic async_reset_check();
      reset = 1'b1;
      #1;
      chk("reset_rgb", int'(rgb), 0);
      chk("reset_state", int'(game_state), 0);
      chk("reset_lives", int'(lives), 3);
      m_reset();
      held = 4'b0000;
      key_start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_rgb", int'(rgb), 0);
      chk("reset_state", int'(game_state), 0);
      chk("reset_lives", int'(lives), 3);
      reset = 1'b0;

      repeat (3) frame(3);
      press_start();
      edge_probe();
      pip_probe();

      held = 4'b0001;                       // right for 10 ticks
      repeat (10) frame(2);
      edge_probe();
      held = 4'b0010;                       // left past the edge
      repeat (15) frame(2);
      edge_probe();
      held = 4'b0100;                       // down at the bottom clamp
      repeat (5) frame(2);
      edge_probe();

      held = 4'b0000;
      hit_frame();                          // first hit
      edge_probe();
      pip_probe();
      hit_frame();                          // immune contact
      for (int f = 0; f < 64; f++) frame(3); // blink window, sprite probes
      hit_frame();
      pip_probe();
      for (int f = 0; f < 62; f++) frame(1);
      hit_frame();                          // third hit ends the game
      probe(4, 0);
      press_start();
      probe(2, 0);
      press_start();
      pip_probe();

      for (int pass = 0; pass < 2; pass++) begin
         held = 4'b0001;
         repeat (312) frame(1);
         held = 4'b1000;
         repeat (217) frame(1);
         edge_probe();
         held = 4'b0000;
         if (pass == 0) hit_frame();       // hit beats goal on the same tick
         else cyc(1'b0, 0, 481, 1'b0, 1'b0);
         probe(3, 0);
      end

      press_start();
      press_start();
      held = 4'b0001;
      repeat (6) frame(2);
      cyc(1'b0, m_sx + 2, m_sy + 2, 1'b0, 1'b0);
      async_reset_check();

      press_start();
      for (int f = 0; f < 200; f++) begin
         if ($urandom_range(0, 3) == 0) held = 4'($urandom_range(0, 15));
         probe(3, 15);
         if ($urandom_range(0, 29) == 0) press_start();
         cyc(1'b0, 0, 481, 1'b0, 1'b0);
      end
      probe(2, 0);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
